// File: rtl/rv32_muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer: 1-bit-per-cycle shift-add multiplier and restoring divider.
// Optional macro MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are all zero.
module rv32_muldiv_sequencer #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_subcode,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal
);
    localparam logic [6:0] IOP_MUL    = 7'h04;
    localparam logic [6:0] IOP_MULH   = 7'h05;
    localparam logic [6:0] IOP_MULHSU = 7'h06;
    localparam logic [6:0] IOP_DIV    = 7'h08;
    localparam logic [6:0] IOP_REM    = 7'h0A;
    localparam logic [6:0] IOP_REMU   = 7'h0B;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    state_e state_q, state_d;

    logic        accept, req_legal, req_is_div, req_is_rem;
    logic        sign_a, sign_b, div_zero, div_ovf, fast;
    logic [31:0] mag_a, mag_b, fast_result;

    logic        is_div_q, is_rem_q, mul_low_q, neg_q;
    logic [5:0]  cnt_q;
    logic [63:0] a_q, acc_q;
    logic [31:0] b_q;

    logic        iter_done, div_ge;
    logic [63:0] mul_sum, mul_p;
    logic [32:0] div_shift;
    logic [31:0] div_diff, quo, rem, final_result;

    assign req_ready = rst_n && !flush && (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign accept    = req_valid && req_ready;

    // Request decode: legality, signedness and the single-cycle special cases.
    assign req_legal  = (req_subcode >= IOP_MUL) && (req_subcode <= IOP_REMU);
    assign req_is_div = req_subcode[3];
    assign req_is_rem = req_subcode[1];
    assign sign_a     = req_rs1[31] && (req_subcode inside {IOP_MUL, IOP_MULH, IOP_MULHSU, IOP_DIV, IOP_REM});
    assign sign_b     = req_rs2[31] && (req_subcode inside {IOP_MUL, IOP_MULH, IOP_DIV, IOP_REM});
    assign mag_a      = sign_a ? -req_rs1 : req_rs1;
    assign mag_b      = sign_b ? -req_rs2 : req_rs2;
    assign div_zero   = req_legal && req_is_div && (req_rs2 == 32'd0);
    assign div_ovf    = (req_subcode inside {IOP_DIV, IOP_REM}) &&
                        (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
    assign fast       = !req_legal || div_zero || div_ovf;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        fast_result = 32'd0;
        if (div_zero)
            fast_result = req_is_rem ? req_rs1 : 32'hFFFF_FFFF;
        else if (div_ovf)
            fast_result = req_is_rem ? 32'd0 : 32'h8000_0000;
    end

    // Iteration datapath; remainder stays below the divisor so a 32-bit difference suffices.
    assign mul_sum   = acc_q + (b_q[0] ? a_q : 64'd0);
    assign div_shift = {acc_q[31:0], a_q[31]};
    assign div_ge    = div_shift >= {1'b0, b_q};
    assign div_diff  = div_shift[31:0] - b_q;

    assign mul_p = neg_q ? -acc_q : acc_q;
    assign quo   = neg_q ? -a_q[31:0] : a_q[31:0];
    assign rem   = neg_q ? -acc_q[31:0] : acc_q[31:0];
    assign final_result = is_div_q ? (is_rem_q ? rem : quo)
                                   : (mul_low_q ? mul_p[31:0] : mul_p[63:32]);

`ifdef MULDIV_EARLY_OUT_EN
    assign iter_done = (cnt_q == 6'd32) || (!is_div_q && (cnt_q != 6'd0) && (b_q == 32'd0));
`else
    assign iter_done = (cnt_q == 6'd32);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast ? DONE : CALC;
            CALC:    if (iter_done) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath and response registers are all reset so an aborted op leaves no stale result behind.
        if (!rst_n) begin
            is_div_q    <= 1'b0;
            is_rem_q    <= 1'b0;
            mul_low_q   <= 1'b0;
            neg_q       <= 1'b0;
            cnt_q       <= 6'd0;
            a_q         <= 64'd0;
            b_q         <= 32'd0;
            acc_q       <= 64'd0;
            rsp_result  <= 32'd0;
            rsp_tag     <= '0;
            rsp_illegal <= 1'b0;
        end else if (accept) begin
            is_div_q    <= req_is_div;
            is_rem_q    <= req_is_rem;
            mul_low_q   <= (req_subcode == IOP_MUL);
            neg_q       <= (req_is_div && req_is_rem) ? sign_a : (sign_a ^ sign_b);
            cnt_q       <= 6'd0;
            a_q         <= {32'd0, mag_a};
            b_q         <= mag_b;
            acc_q       <= 64'd0;
            rsp_tag     <= req_tag;
            rsp_illegal <= !req_legal;
            if (fast) rsp_result <= fast_result;
        end else if (state_q == CALC && !flush) begin
            if (iter_done) begin
                rsp_result <= final_result;
            end else begin
                cnt_q <= cnt_q + 6'd1;
                if (is_div_q) begin
                    a_q   <= {32'd0, a_q[30:0], div_ge};
                    acc_q <= div_ge ? {32'd0, div_diff} : {31'd0, div_shift};
                end else begin
                    acc_q <= mul_sum;
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                end
            end
        end
    end
endmodule

// File: tb/tb_rv32_muldiv_sequencer.sv
// Directed self-checking bench for rv32_muldiv_sequencer (expected latencies follow MULDIV_EARLY_OUT_EN).
module tb_rv32_muldiv_sequencer;
    localparam int TAG_W = 5;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    localparam logic [6:0] MUL = 7'h04, MULH = 7'h05, MULHSU = 7'h06, MULHU = 7'h07;
    localparam logic [6:0] DIV = 7'h08, DIVU = 7'h09, REM = 7'h0A, REMU = 7'h0B;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [6:0]       req_subcode = '0;
    logic [31:0]      req_rs1 = '0;
    logic [31:0]      req_rs2 = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [6:0]  sc;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] exp;
        logic        ill;
        int          lat_def;
        int          lat_eo;
    } vec_t;

    rv32_muldiv_sequencer #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_subcode(req_subcode),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    // Presents one request and returns just after its accepting edge.
    task automatic issue_op(input logic [6:0] sc, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        for (int w = 0; w < 100 && !req_ready; w++) @(negedge clk);
        if (req_ready) begin
            req_valid = 1'b1; req_subcode = sc; req_rs1 = a; req_rs2 = b; req_tag = tag;
            @(posedge clk);
            #1 req_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    // Counts edges after the accept edge until rsp_valid is seen; leaves time at that negedge.
    task automatic wait_rsp(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [6:0] sc, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tg,
                          output logic ill, output int lat, output bit ok);
        bit issued;
        issue_op(sc, a, b, tag, issued);
        ok = 1'b0; lat = 0;
        if (issued) wait_rsp(lat, ok);
        res = rsp_result; tg = rsp_tag; ill = rsp_illegal;
        if (ok) begin
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic run_table(input string name, input vec_t v[$]);
        logic [31:0] res;
        logic [4:0]  tg;
        logic        ill;
        int          lat, exp_lat;
        bit          ok;
        foreach (v[i]) begin
            run_op(v[i].sc, v[i].a, v[i].b, v[i].tag, res, tg, ill, lat, ok);
            exp_lat = EARLY ? v[i].lat_eo : v[i].lat_def;
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s[%0d] timeout: no rsp_valid within budget", name, i);
            end else begin
                n_tests++;
                if (res !== v[i].exp) begin
                    n_fail++;
                    $display("FAIL %s[%0d] result: got %h expected %h", name, i, res, v[i].exp);
                end
                n_tests++;
                if (tg !== v[i].tag) begin
                    n_fail++;
                    $display("FAIL %s[%0d] tag: got %0d expected %0d", name, i, tg, v[i].tag);
                end
                n_tests++;
                if (ill !== v[i].ill) begin
                    n_fail++;
                    $display("FAIL %s[%0d] illegal: got %b expected %b", name, i, ill, v[i].ill);
                end
                n_tests++;
                if (lat != exp_lat) begin
                    n_fail++;
                    $display("FAIL %s[%0d] latency: got %0d expected %0d", name, i, lat, exp_lat);
                end
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_illegal} !== 3'b000 || rsp_result !== 32'd0 || rsp_tag !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%b vld=%b ill=%b res=%h tag=%0d expected all 0",
                     req_ready, rsp_valid, rsp_illegal, rsp_result, rsp_tag);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b expected 1", req_ready);
        end
    endtask

    task automatic test_divide();
        vec_t v[$];
        v.push_back(vec_t'{DIV,  32'hFFFF_FFF9, 32'h2,         5'd7,  32'hFFFF_FFFD, 1'b0, 33, 33});
        v.push_back(vec_t'{REM,  32'hFFFF_FFF9, 32'h2,         5'd8,  32'hFFFF_FFFF, 1'b0, 33, 33});
        v.push_back(vec_t'{DIVU, 32'd100,       32'd7,         5'd1,  32'd14,        1'b0, 33, 33});
        v.push_back(vec_t'{REMU, 32'd100,       32'd7,         5'd2,  32'd2,         1'b0, 33, 33});
        v.push_back(vec_t'{DIV,  32'd7,         32'hFFFF_FFFE, 5'd3,  32'hFFFF_FFFD, 1'b0, 33, 33});
        v.push_back(vec_t'{REM,  32'd7,         32'hFFFF_FFFE, 5'd4,  32'd1,         1'b0, 33, 33});
        v.push_back(vec_t'{DIVU, 32'hFFFF_FFFF, 32'd1,         5'd5,  32'hFFFF_FFFF, 1'b0, 33, 33});
        v.push_back(vec_t'{DIVU, 32'h1234_5678, 32'd0,         5'd9,  32'hFFFF_FFFF, 1'b0, 1, 1});
        v.push_back(vec_t'{REMU, 32'h1234_5678, 32'd0,         5'd10, 32'h1234_5678, 1'b0, 1, 1});
        v.push_back(vec_t'{DIV,  32'hFFFF_FFFB, 32'd0,         5'd11, 32'hFFFF_FFFF, 1'b0, 1, 1});
        v.push_back(vec_t'{DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b0, 1, 1});
        v.push_back(vec_t'{REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1'b0, 1, 1});
        run_table("divide", v);
    endtask

    task automatic test_multiply();
        vec_t v[$];
        v.push_back(vec_t'{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'h0000_0001, 1'b0, 33, 2});
        v.push_back(vec_t'{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0, 33, 33});
        v.push_back(vec_t'{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, 1'b0, 33, 33});
        v.push_back(vec_t'{MULH,   32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 1'b0, 33, 33});
        v.push_back(vec_t'{MUL,    32'd5,         32'd3,         5'd5, 32'd15,        1'b0, 33, 3});
        v.push_back(vec_t'{MUL,    32'hFFFF_FFFD, 32'd7,         5'd6, 32'hFFFF_FFEB, 1'b0, 33, 4});
        v.push_back(vec_t'{MULH,   32'hFFFF_FFFD, 32'd7,         5'd7, 32'hFFFF_FFFF, 1'b0, 33, 4});
        v.push_back(vec_t'{MULHU,  32'h8000_0000, 32'd4,         5'd8, 32'h0000_0002, 1'b0, 33, 4});
        v.push_back(vec_t'{MUL,    32'd1234,      32'd0,         5'd9, 32'd0,         1'b0, 33, 2});
        run_table("multiply", v);
    endtask

    task automatic test_illegal();
        vec_t v[$];
        v.push_back(vec_t'{7'h44, 32'd5, 32'd3, 5'd20, 32'd0, 1'b1, 1, 1});
        v.push_back(vec_t'{7'h00, 32'd5, 32'd3, 5'd21, 32'd0, 1'b1, 1, 1});
        v.push_back(vec_t'{7'h0C, 32'd9, 32'd2, 5'd22, 32'd0, 1'b1, 1, 1});
        v.push_back(vec_t'{7'h03, 32'd9, 32'd2, 5'd23, 32'd0, 1'b1, 1, 1});
        run_table("illegal", v);
    endtask

    task automatic test_hold();
        bit ok;
        int lat;
        issue_op(DIVU, 32'd100, 32'd7, 5'd3, ok);
        wait_rsp(lat, ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL hold timeout: no rsp_valid within budget");
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'd14 || rsp_tag !== 5'd3 || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_stable[%0d]: got vld=%b res=%h tag=%0d rdy=%b expected 1 0000000e 3 0",
                         c, rsp_valid, rsp_result, rsp_tag, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: got vld=%b rdy=%b expected 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_flush();
        bit ok, seen;
        int lat;
        logic [31:0] res;
        logic [4:0]  tg;
        logic        ill;
        // Flush during CALC.
        issue_op(DIV, 32'd1000, 32'd3, 5'd6, ok);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready_low: got %b expected 0", req_ready);
        end
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_calc: got vld=%b rdy=%b expected 0 1", rsp_valid, req_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_no_rsp: got rsp_valid seen=%b expected 0", seen);
        end
        run_op(DIVU, 32'd100, 32'd7, 5'd14, res, tg, ill, lat, ok);
        n_tests++;
        if (!ok || res !== 32'd14 || tg !== 5'd14) begin
            n_fail++;
            $display("FAIL flush_next_op: got ok=%b res=%h tag=%0d expected 1 0000000e 14", ok, res, tg);
        end
        // Flush coincident with a request.
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_subcode = DIVU; req_rs1 = 32'd50; req_rs2 = 32'd5; req_tag = 5'd15;
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_coincident_ready: got %b expected 0", req_ready);
        end
        @(posedge clk);
        #1 begin flush = 1'b0; req_valid = 1'b0; end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_coincident_accepted: got busy=%b expected 0", seen);
        end
        // Flush while a response is pending.
        issue_op(MUL, 32'd5, 32'd3, 5'd16, ok);
        wait_rsp(lat, ok);
        flush = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 begin flush = 1'b0; rsp_ready = 1'b0; end
        @(negedge clk);
        n_tests++;
        if (!ok || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_done: got ok=%b vld=%b rdy=%b expected 1 0 1", ok, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int lat;
        logic [31:0] res;
        logic [4:0]  tg;
        logic        ill;
        issue_op(DIV, 32'd77, 32'd5, 5'd17, ok);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_tag !== 5'd0 || rsp_result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid_values: got vld=%b rdy=%b tag=%0d res=%h expected 0 0 0 0",
                     rsp_valid, req_ready, rsp_tag, rsp_result);
        end
        @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_no_rsp: got rsp_valid seen=%b expected 0", seen);
        end
        run_op(REMU, 32'd77, 32'd5, 5'd18, res, tg, ill, lat, ok);
        n_tests++;
        if (!ok || res !== 32'd2 || tg !== 5'd18) begin
            n_fail++;
            $display("FAIL reset_mid_next_op: got ok=%b res=%h tag=%0d expected 1 00000002 18", ok, res, tg);
        end
    endtask

    initial begin
        test_reset();
        test_divide();
        test_multiply();
        test_illegal();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
